// File: rtl/ula_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ula_seq
//  Description : RV32/64 OP-class ALU with valid/ready handshakes.
//                Base integer ops finish in one cycle. M-extension multiply
//                and divide run iteratively, one bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data1_in,
  input  logic [XLEN-1:0] data2_in,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data_out,
  output logic            illegal
);

  localparam int         CNT_W   = $clog2(XLEN);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    K_BASE = 2'd0,
    K_MUL  = 2'd1,
    K_DIV  = 2'd2,
    K_ILL  = 2'd3
  } kind_e;

  // Architectural state
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;       // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0]   opb_q;       // multiplicand / divisor magnitude
  logic [XLEN-1:0]   dvd_q;       // raw dividend, returned as remainder on divide by zero
  logic              neg_q;       // negate product / quotient at the end
  logic              rneg_q;      // negate remainder at the end
  logic              sel_q;       // MUL: take high half; DIV: take remainder
  logic              div0_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              illegal_q;
  logic [XLEN-1:0]   data_out_q;

  // Decode and single-cycle datapath
  kind_e              kind_w;
  logic [XLEN-1:0]    base_res_w;
  logic [SHAMT_W-1:0] shamt_w;

  assign shamt_w = data2_in[SHAMT_W-1:0];

  // Classify the request and compute any base-op result straight from the inputs
  always_comb begin
    kind_w     = K_ILL;
    base_res_w = '0;
    if (opcode == OPC_OP) begin
      case (funct7)
        F7_BASE: begin
          kind_w = K_BASE;
          case (funct3)
            3'b000:  base_res_w = data1_in + data2_in;
            3'b001:  base_res_w = data1_in << shamt_w;
            3'b010:  base_res_w = {{(XLEN-1){1'b0}}, ($signed(data1_in) < $signed(data2_in))};
            3'b011:  base_res_w = {{(XLEN-1){1'b0}}, (data1_in < data2_in)};
            3'b100:  base_res_w = data1_in ^ data2_in;
            3'b101:  base_res_w = data1_in >> shamt_w;
            3'b110:  base_res_w = data1_in | data2_in;
            default: base_res_w = data1_in & data2_in;
          endcase
        end
        F7_ALT: begin
          if (funct3 == 3'b000) begin
            kind_w     = K_BASE;
            base_res_w = data1_in - data2_in;
          end else if (funct3 == 3'b101) begin
            kind_w     = K_BASE;
            base_res_w = $signed(data1_in) >>> shamt_w;
          end
        end
        F7_MEXT: kind_w = funct3[2] ? K_DIV : K_MUL;
        default: kind_w = K_ILL;
      endcase
    end
  end

  // Operand signedness and magnitudes; the iterative engines work unsigned
  logic            a_sgn_w, b_sgn_w, a_neg_w, b_neg_w;
  logic [XLEN-1:0] mag_a_w, mag_b_w;

  // Derive operand magnitudes so both engines only ever see unsigned values
  always_comb begin
    if (funct3[2]) begin
      a_sgn_w = ~funct3[0];
      b_sgn_w = ~funct3[0];
    end else begin
      a_sgn_w = (funct3 == 3'b001) || (funct3 == 3'b010);
      b_sgn_w = (funct3 == 3'b001);
    end
    a_neg_w = a_sgn_w & data1_in[XLEN-1];
    b_neg_w = b_sgn_w & data2_in[XLEN-1];
    mag_a_w = a_neg_w ? ('0 - data1_in) : data1_in;
    mag_b_w = b_neg_w ? ('0 - data2_in) : data2_in;
  end

  // One step of each engine plus the sign-corrected final results
  logic [XLEN:0]     mul_sum_w;
  logic [2*XLEN-1:0] mul_next_w;
  logic [2*XLEN-1:0] prod_w;
  logic [XLEN-1:0]   res_mul_w;
  logic [XLEN:0]     div_shift_w;
  logic [XLEN:0]     div_diff_w;
  logic [2*XLEN-1:0] div_next_w;
  logic [XLEN-1:0]   quo_w, rem_w, quo_fix_w, rem_fix_w, res_div_w;

  // Shift-add multiply step and restoring-divide step, with end-of-op fixups
  always_comb begin
    mul_sum_w  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next_w = {mul_sum_w, acc_q[XLEN-1:1]};
    prod_w     = neg_q ? ('0 - mul_next_w) : mul_next_w;
    res_mul_w  = sel_q ? prod_w[2*XLEN-1:XLEN] : prod_w[XLEN-1:0];

    div_shift_w = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_w  = div_shift_w - {1'b0, opb_q};
    if (div_diff_w[XLEN]) begin
      div_next_w = {div_shift_w[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next_w = {div_diff_w[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    quo_w = div_next_w[XLEN-1:0];
    rem_w = div_next_w[2*XLEN-1:XLEN];

    // Divide by zero bypasses the sign fixups; signed overflow falls out naturally
    if (div0_q) begin
      quo_fix_w = '1;
      rem_fix_w = dvd_q;
    end else begin
      quo_fix_w = neg_q  ? ('0 - quo_w) : quo_w;
      rem_fix_w = rneg_q ? ('0 - rem_w) : rem_w;
    end
    res_div_w = sel_q ? rem_fix_w : quo_fix_w;
  end

  // Control FSM with registered handshake outputs and the iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      dvd_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      sel_q       <= 1'b0;
      div0_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      data_out_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            case (kind_w)
              K_MUL: begin
                state_q <= S_MUL;
                cnt_q   <= CNT_W'(XLEN-1);
                acc_q   <= {{XLEN{1'b0}}, mag_a_w};
                opb_q   <= mag_b_w;
                neg_q   <= a_neg_w ^ b_neg_w;
                sel_q   <= (funct3[1:0] != 2'b00);
              end
              K_DIV: begin
                state_q <= S_DIV;
                cnt_q   <= CNT_W'(XLEN-1);
                acc_q   <= {{XLEN{1'b0}}, mag_a_w};
                opb_q   <= mag_b_w;
                dvd_q   <= data1_in;
                neg_q   <= a_neg_w ^ b_neg_w;
                rneg_q  <= a_neg_w;
                sel_q   <= funct3[1];
                div0_q  <= (data2_in == '0);
              end
              K_BASE: begin
                state_q     <= S_DONE;
                data_out_q  <= base_res_w;
                illegal_q   <= 1'b0;
                out_valid_q <= 1'b1;
              end
              default: begin
                state_q     <= S_DONE;
                data_out_q  <= '0;
                illegal_q   <= 1'b1;
                out_valid_q <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_q <= mul_next_w;
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            data_out_q  <= res_mul_w;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV: begin
          acc_q <= div_next_w;
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            data_out_q  <= res_div_w;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ula_seq
//  Description : Scoreboard bench for ula_seq. A driver issues directed and
//                random requests and queues the expected responses; a
//                monitor pops and compares each result the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] data1_in = '0;
  logic [XLEN-1:0] data2_in = '0;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] data_out;
  logic            illegal;

  ula_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1_in  (data1_in),
    .data2_in  (data2_in),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] d;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   hold_next = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural reference: plain wide arithmetic straight from the ISA rules
  function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          sh;
    r   = '0;
    ill = 1'b1;
    lat = 1;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    sh  = int'(b[4:0]);
    if (opc != 7'b0110011) return;
    if (f7 == 7'h00) begin
      ill = 1'b0;
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << sh;
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20) begin
      if (f3 == 3'd0) begin
        ill = 1'b0;
        r   = a - b;
      end else if (f3 == 3'd5) begin
        ill = 1'b0;
        r   = 32'(sa >>> sh);
      end
    end else if (f7 == 7'h01) begin
      ill = 1'b0;
      lat = 33;
      case (f3)
        3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
        3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
        3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
        3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: r = (b == 0) ? a : 32'(sa % sb);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
  endfunction

  // Drive one request, wait for acceptance, and queue its expected response
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit use_x, input logic [31:0] xd, input logic xi, input bit record);
    logic [31:0] md;
    logic        mi;
    int          ml;
    int          budget;
    exp_t        e;
    model(opc, f3, f7, a, b, md, mi, ml);
    @(negedge clk);
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    data1_in = a;
    data2_in = b;
    in_valid = 1'b1;
    budget   = 200;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 required 1 (t=%0t)", $time);
      in_valid = 1'b0;
      return;
    end
    if (record) begin
      e.d   = use_x ? xd : md;
      e.ill = use_x ? xi : mi;
      e.lat = ml;
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    // Scramble the inputs while the operation runs; it must not care
    in_valid = 1'b0;
    data1_in = $urandom;
    data2_in = $urandom;
    funct3   = 3'($urandom);
    funct7   = 7'($urandom);
    opcode   = 7'($urandom);
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (b >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: pending got %0d required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops one expectation per presented result and polices the handshake
  initial begin : monitor
    bit          showing;
    bit          consumed;
    int          hold;
    logic [31:0] hd;
    logic        hi;
    exp_t        e;
    showing  = 1'b0;
    consumed = 1'b0;
    hold     = 0;
    hd       = '0;
    hi       = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        showing   = 1'b0;
        consumed  = 1'b0;
        hold      = 0;
        out_ready = 1'b0;
      end else begin
        if (consumed) begin
          chk("out_valid_drop", 32'(out_valid), 32'd0);
          consumed = 1'b0;
        end
        if (out_valid) begin
          if (!showing) begin
            showing = 1'b1;
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_result: got %h with nothing expected", data_out);
            end else begin
              e = exp_q.pop_front();
              chk("data_out", data_out, e.d);
              chk("illegal", 32'(illegal), 32'(e.ill));
              chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
            hd   = data_out;
            hi   = illegal;
            hold = (hold_next >= 0) ? hold_next : int'($urandom_range(0, 2));
            hold_next = -1;
          end else begin
            chk("data_out_stable", data_out, hd);
            chk("illegal_stable", 32'(illegal), 32'(hi));
          end
          chk("in_ready_while_done", 32'(in_ready), 32'd0);
          if (hold > 0) begin
            hold--;
            out_ready = 1'b0;
          end else begin
            out_ready = 1'b1;
            consumed  = 1'b1;
            showing   = 1'b0;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [6:0] OP = 7'b0110011;

  initial begin : driver
    // Reset values, checked asynchronously before any clock activity matters
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors with externally known answers
    issue(OP, 3'd0, 7'h00, 32'h5555_5555, 32'hAAAA_AAAA, 1, 32'hFFFF_FFFF, 1'b0, 1);
    issue(OP, 3'd0, 7'h20, 32'h0380_0155, 32'h0005_5400, 1, 32'h037A_AD55, 1'b0, 1);
    issue(OP, 3'd5, 7'h20, 32'h8380_0155, 32'h0000_0024, 1, 32'hF838_0015, 1'b0, 1);
    issue(OP, 3'd2, 7'h00, 32'h0000_0004, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0, 1);
    issue(OP, 3'd3, 7'h00, 32'h0000_0004, 32'hFFFF_FFFF, 1, 32'h0000_0001, 1'b0, 1);
    issue(OP, 3'd0, 7'h01, 32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 1'b0, 1);
    issue(OP, 3'd1, 7'h01, 32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 1'b0, 1);
    issue(OP, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 1'b0, 1);
    issue(OP, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFD, 1'b0, 1);
    issue(OP, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, 1'b0, 1);
    issue(OP, 3'd5, 7'h01, 32'h1234_5678, 32'h0000_0000, 1, 32'hFFFF_FFFF, 1'b0, 1);
    issue(OP, 3'd7, 7'h01, 32'h1234_5678, 32'h0000_0000, 1, 32'h1234_5678, 1'b0, 1);
    issue(OP, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0, 1);
    issue(OP, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0, 1);
    drain();

    // Consumer stalls for 5 cycles; a queued request must wait for the handshake
    hold_next = 5;
    issue(OP, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_0234, 1, 32'h0000_1234, 1'b0, 1);
    issue(OP, 3'd4, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFF00_FF00, 1'b0, 1);
    drain();

    // Reset ten cycles into a divide: nothing may come out of it
    issue(OP, 3'd5, 7'h01, 32'hDEAD_BEEF, 32'h0000_0013, 0, 32'h0, 1'b0, 0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midop_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midop_rst_data_out", data_out, 32'd0);
    repeat (3) @(negedge clk);
    chk("midop_rst_held_in_ready", 32'(in_ready), 32'd1);
    chk("midop_rst_held_out_valid", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    issue(7'b0010011, 3'd0, 7'h00, 32'h1111_1111, 32'h2222_2222, 1, 32'h0, 1'b1, 1);
    repeat (40) @(negedge clk);
    drain();

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [6:0] opc;
      logic [6:0] f7;
      opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : OP;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      issue(opc, 3'($urandom), f7, rand_operand(), rand_operand(), 0, 32'h0, 1'b0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
